shift_serializer_8bit: RTL and testbench

Sequential counterpart to the team's combinational 8-bit left/right shifter. It accepts an 8-bit parallel word through a valid/ready handshake and shifts it out one bit per enabled clock. The direction control selects MSB-first (shift left) or LSB-first (shift right) order. It sits between a parallel data source and a serial sink; the sink can stall it with a shift-enable input.

---
 rtl/shift_serializer_8bit_if.sv | 28 ++
 rtl/shift_serializer_8bit.sv | 60 ++++++
 tb/tb_shift_serializer_8bit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/shift_serializer_8bit_if.sv
// shift_serializer_8bit_if: source/sink handshake bundle for the serializer.
// Ports (from the slave's view):
//   a, lr, load_valid   parallel word, direction, load request      (in)
//   load_ready          idle, will take a word                      (out)
//   shift_en            sink accepts the current bit                (in)
//   sout, sout_valid    serial bit and its qualifier                (out)
//   sout_last, done     last bit of frame, post-frame pulse         (out)
//   y                   shift register contents                     (out)
interface shift_serializer_8bit_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] a;
    logic             lr;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             done;
    logic [WIDTH-1:0] y;
    modport master (
        output a, lr, load_valid, shift_en,
        input  load_ready, sout, sout_valid, sout_last, done, y
    );
    modport slave (
        input  a, lr, load_valid, shift_en,
        output load_ready, sout, sout_valid, sout_last, done, y
    );
endinterface

// File: rtl/shift_serializer_8bit.sv
// shift_serializer_8bit: parallel-to-serial shifter, MSB- or LSB-first.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of shift_serializer_8bit_if (load handshake, serial out, y)
module shift_serializer_8bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input logic                      clk,
    input logic                      rst,
    shift_serializer_8bit_if.slave   bus
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t             state, next;
    logic [WIDTH-1:0]   sreg;
    logic [CNT_W-1:0]   cnt;
    logic               dir;
    logic               done_q;
    logic               consume;
    logic               last;
    logic               accept;
    always_comb begin
        accept  = (state == IDLE) && bus.load_valid;
        consume = (state == SHIFT) && bus.shift_en;
        last    = cnt == CNT_W'(WIDTH - 1);
        next    = state;
        if (state == IDLE)
            next = bus.load_valid ? SHIFT : IDLE;
        else
            next = (consume && last) ? IDLE : SHIFT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            dir    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= next;
            done_q <= consume && last;
            if (accept) begin
                sreg <= bus.a;
                dir  <= bus.lr;
                cnt  <= '0;
            end else if (consume) begin
                sreg <= dir ? (sreg >> 1) : (sreg << 1);
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end
    assign bus.load_ready = state == IDLE;
    assign bus.sout_valid = state == SHIFT;
    // Forced low in IDLE so a just-loaded register never leaks onto sout.
    assign bus.sout       = (state == SHIFT) && (dir ? sreg[0] : sreg[WIDTH-1]);
    assign bus.sout_last  = (state == SHIFT) && last;
    assign bus.done       = done_q;
    assign bus.y          = sreg;
endmodule

// File: tb/tb_shift_serializer_8bit.sv
// tb_shift_serializer_8bit: scoreboard bench for shift_serializer_8bit.
// Ports: none (top-level bench).
module tb_shift_serializer_8bit;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic exp_q[$];
    logic pend = 1'b0;
    shift_serializer_8bit_if #(.WIDTH(W)) bus ();
    shift_serializer_8bit #(.WIDTH(W), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    // Monitor: sout/sout_last follow the queue head; done must pulse only after the last pop.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend = 1'b0;
        end else begin
            chk("done", 32'(bus.done), 32'(pend));
            if (pend) chk("ready_at_done", 32'(bus.load_ready), 32'd1);
            pend = 1'b0;
            if (bus.sout_valid) begin
                if (exp_q.size() == 0) chk("unexpected_bit", 32'(bus.sout_valid), 32'd0);
                else begin
                    chk("sout", 32'(bus.sout), 32'(exp_q[0]));
                    chk("sout_last", 32'(bus.sout_last), 32'(exp_q.size() == 1));
                    chk("ready_busy", 32'(bus.load_ready), 32'd0);
                    if (bus.shift_en) begin
                        void'(exp_q.pop_front());
                        pend = exp_q.size() == 0;
                    end
                end
            end else begin
                chk("sout_idle", {30'd0, bus.sout, bus.sout_last}, 32'd0);
            end
        end
    end
    task automatic send(input logic [W-1:0] w, input logic d);
        @(posedge clk); #1;
        chk("ready_before_load", 32'(bus.load_ready), 32'd1);
        bus.a = w;
        bus.lr = d;
        bus.load_valid = 1'b1;
        for (int i = 0; i < W; i++) exp_q.push_back(d ? w[i] : w[W-1-i]);
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
    endtask
    task automatic wait_done(input int exp_cyc, input string tag);
        int  c = 0;
        bit  seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            c++;
            if (bus.done) seen = 1;
        end
        chk(tag, 32'(c), 32'(exp_cyc));
        chk({tag, "_y0"}, 32'(bus.y), 32'd0);
    endtask
    initial begin
        logic       held_s;
        logic [W-1:0] held_y;
        int         c;
        bus.a = '0;
        bus.lr = 1'b0;
        bus.load_valid = 1'b0;
        bus.shift_en = 1'b1;
        #12 rst = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_valid", 32'(bus.sout_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        // MSB-first frame
        send(8'b10010110, 1'b0);
        wait_done(W, "msb_frame");
        // LSB-first frame with intermediate register check
        send(8'b10010110, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        chk("lsb_y3", 32'(bus.y), 32'h12);
        wait_done(W - 3, "lsb_frame");
        // Stall after the 2nd bit for 5 cycles
        send(8'b10010110, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        bus.shift_en = 1'b0;
        held_s = bus.sout;
        held_y = bus.y;
        chk("stall_bit", 32'(held_s), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_sout", 32'(bus.sout), 32'(held_s));
            chk("stall_y", 32'(bus.y), 32'(held_y));
        end
        bus.shift_en = 1'b1;
        wait_done(W - 2, "stall_frame");
        // Mid-frame input churn is ignored
        send(8'h3C, 1'b1);
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            c++;
            if (bus.done) break;
            chk("churn_ready", 32'(bus.load_ready), 32'd0);
            bus.a = W'($urandom);
            bus.lr = ~bus.lr;
            bus.load_valid = 1'b1;
        end
        bus.load_valid = 1'b0;
        chk("churn_frame", 32'(c), 32'(W));
        @(posedge clk); #1;
        chk("churn_no_reload", 32'(bus.sout_valid), 32'd0);
        // Asynchronous reset after the 4th bit
        send(8'hF0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.sout_valid), 32'd0);
        chk("arst_ready", 32'(bus.load_ready), 32'd1);
        chk("arst_y", 32'(bus.y), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        send(8'hA5, 1'b0);
        wait_done(W, "post_rst_frame");
        repeat (2) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
